mem_port_arbiter: RTL and testbench

//   Two-requester arbiter for the single-port data memory behind MAR/MDR.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing two req/ack ports onto one single-port data memory.
// Latency: ack pulses MEM_LAT+1 cycles after the selecting edge; a transaction occupies MEM_LAT+2 cycles.
// Backpressure: requesters hold req until ack; on a tie the loser waits at most one foreign transaction.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr_rdn0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr_rdn1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        grant,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Captured request of the current owner; drives the memory address/data pins.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // lat_cnt counts down the remaining chip-select cycles; 0 marks the last one.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       prio;
    logic       sel;
    logic       any_req;
    logic [3:0] lat_cnt;
    xact_t      cur;
    xact_t      sel_xact;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and choice of the port to serve on a tie (priority pointer).
    always_comb begin
        state_nxt = state;
        any_req   = req0 | req1;
        sel       = (req0 & req1) ? prio : req1;
        sel_xact  = sel ? {wr_rdn1, addr1, wdata1} : {wr_rdn0, addr0, wdata0};
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: if (lat_cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the winner's request, count the access, capture read data, rotate priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= 1'b0;
            prio    <= 1'b0;
            lat_cnt <= 4'd0;
            cur     <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= sel;
                        cur     <= sel_xact;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                S_ACCESS: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (!cur.wr) begin
                        if (owner) rdata1 <= mem_rdata;
                        else       rdata0 <= mem_rdata;
                    end
                end
                S_DONE: begin
                    prio <= ~owner;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately.
    assign grant     = (state == S_ACCESS || state == S_DONE) ? {owner, ~owner} : 2'b00;
    assign mem_cs    = (state == S_ACCESS);
    assign mem_we    = mem_cs & cur.wr;
    assign mem_addr  = cur.addr;
    assign mem_wdata = cur.wdata;
    assign ack0      = (state == S_DONE) & ~owner;
    assign ack1      = (state == S_DONE) & owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed and randomized stimulus.
// Latency: model tracks each transaction by its cycle offset from the selecting edge.
// Backpressure: bench requesters hold req until they see their ack.
module tb_mem_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
    logic          ack0, ack1, mem_cs, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr_rdn0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .wr_rdn1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .grant(grant), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Transaction model: m_k is the cycle offset since the selecting edge (1..LAT access, LAT+1 ack).
    logic          m_busy = 1'b0, m_owner = 1'b0, m_prio = 1'b0, m_wr = 1'b0;
    int            m_k = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;

    // Which port wins: a lone requester, otherwise whoever the priority pointer names.
    function automatic logic pick(input logic r0, input logic r1, input logic p);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_k <= 0; m_owner <= 1'b0; m_prio <= 1'b0;
            m_rd0 <= '0; m_rd1 <= '0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                m_owner <= pick(req0, req1, m_prio);
                if (pick(req0, req1, m_prio)) begin
                    m_wr <= wr1; m_addr <= addr1; m_wdata <= wdata1;
                end else begin
                    m_wr <= wr0; m_addr <= addr0; m_wdata <= wdata0;
                end
                m_k    <= 1;
                m_busy <= 1'b1;
            end
        end else if (m_k == LAT + 1) begin
            m_busy <= 1'b0;
            m_prio <= !m_owner;
        end else begin
            if (m_k == LAT && !m_wr) begin
                if (m_owner) m_rd1 <= mem_rdata;
                else         m_rd0 <= mem_rdata;
            end
            m_k <= m_k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic check_cycle();
        logic [1:0] eg;
        logic       ecs, eack;
        eg   = !m_busy ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
        ecs  = m_busy && (m_k <= LAT);
        eack = m_busy && (m_k == LAT + 1);
        chk("grant", grant, eg);
        chk("mem_cs", mem_cs, ecs);
        chk("mem_we", mem_we, ecs && m_wr);
        if (ecs) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("ack0", ack0, eack && !m_owner);
        chk("ack1", ack1, eack && m_owner);
        chk("rdata0", rdata0, m_rd0);
        chk("rdata1", rdata1, m_rd1);
        chk("ack_excl", ack0 && ack1, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_cs"}, mem_cs, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
    endtask

    // Randomized requester: drops req on ack, occasionally abandons early or wiggles its inputs.
    task automatic req_next(input logic ack, input logic c_req, input logic c_wr,
                            input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wdata,
                            output logic n_req, output logic n_wr,
                            output logic [AW-1:0] n_addr, output logic [DW-1:0] n_wdata);
        n_req = c_req; n_wr = c_wr; n_addr = c_addr; n_wdata = c_wdata;
        if (c_req && ack) begin
            n_req = 1'b0;
        end else if (c_req) begin
            if ($urandom_range(0, 39) == 0) n_req = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                n_wr = 1'($urandom); n_addr = AW'($urandom); n_wdata = DW'($urandom);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            n_req = 1'b1; n_wr = 1'($urandom); n_addr = AW'($urandom); n_wdata = DW'($urandom);
        end
    endtask

    initial begin
        int cs_count;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (5) begin
            step();
            chk("idle_grant", grant, 2'b00);
            chk("idle_cs", mem_cs, 1'b0);
        end

        // Read on port 0.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h10; wdata0 = 8'h77; mem_rdata = 8'hA5;
        step();
        chk("rd_cs", mem_cs, 1'b1);
        chk("rd_we", mem_we, 1'b0);
        chk("rd_addr", mem_addr, 8'h10);
        chk("rd_grant", grant, 2'b01);
        addr0 = 8'h99;
        step(); step();
        chk("rd_cs_last", mem_cs, 1'b1);
        chk("rd_addr_held", mem_addr, 8'h10);
        step();
        chk("rd_ack0", ack0, 1'b1);
        chk("rd_rdata0", rdata0, 8'hA5);
        chk("model_rd0", m_rd0, 8'hA5);
        req0 = 1'b0;
        step();
        chk("rd_after_ack", ack0, 1'b0);
        chk("rd_after_grant", grant, 2'b00);
        chk("rd_rdata0_hold", rdata0, 8'hA5);

        // Write on port 1; later input changes must be ignored.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h3F; wdata1 = 8'h5A; mem_rdata = 8'hC3;
        step();
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 8'h3F);
        chk("wr_wdata", mem_wdata, 8'h5A);
        chk("wr_grant", grant, 2'b10);
        addr1 = 8'h00; wdata1 = 8'h00; wr1 = 1'b0;
        step(); step();
        chk("wr_we_last", mem_we, 1'b1);
        chk("wr_wdata_held", mem_wdata, 8'h5A);
        step();
        chk("wr_ack1", ack1, 1'b1);
        chk("wr_ack0_quiet", ack0, 1'b0);
        chk("wr_rdata1_kept", rdata1, 8'h00);
        chk("wr_rdata0_kept", rdata0, 8'hA5);
        req1 = 1'b0;
        step();

        // Port 0 read completes (pointer -> port 1), req0 stays high and is re-served, then reset mid-access.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h20;
        repeat (LAT + 1) step();
        chk("again_ack0", ack0, 1'b1);
        step();
        chk("again_idle", grant, 2'b00);
        step();
        chk("again_grant", grant, 2'b01);
        step();
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        chk("model_rst", m_busy, 1'b0);
        step(); step();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h40;
        rst = 1'b1;

        // Both held high: port 0 first (pointer back at port 0), then strict alternation.
        cs_count = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (mem_cs) cs_count++;
            if (c == 1)  chk("alt_first", grant, 2'b01);
            if (c == 4)  chk("alt_ack0", ack0, 1'b1);
            if (c == 5)  chk("alt_gap", grant, 2'b00);
            if (c == 6)  chk("alt_second", grant, 2'b10);
            if (c == 9)  chk("alt_ack1", ack1, 1'b1);
            if (c == 11) chk("alt_third", grant, 2'b01);
        end
        chk("alt_cs_cycles", cs_count, 12);
        req0 = 1'b0; req1 = 1'b0;
        repeat (LAT + 3) step();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            req_next(ack0, req0, wr0, addr0, wdata0, req0, wr0, addr0, wdata0);
            req_next(ack1, req1, wr1, addr1, wdata1, req1, wr1, addr1, wdata1);
            mem_rdata = DW'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1 check_zero("rand_rst");
                step();
                rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
